// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcode/funct
// constants, ALU operation codes and datapath mux select codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_EXEC_I    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_JAL       = 4'd12,
        S_JR        = 4'd13
    } state_t;

    // Which rule the ALU decoder applies in the current state
    typedef enum logic [1:0] {
        CLS_ADD   = 2'd0,
        CLS_SUB   = 2'd1,
        CLS_RTYPE = 2'd2,
        CLS_ITYPE = 2'd3
    } alu_cls_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_LUI = 3'b101;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_A      = 2'b11;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control-unit <-> datapath bundle: instruction fields and ALU flag in,
// register enables and mux selects out. master = control unit, slave = datapath.
interface mc_ctrl_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_en;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [1:0] pcsource;
    logic       ext_sel;
    logic [2:0] alu_ctrl;
    logic       illegal;

    modport master (
        input  opcode, funct, zero,
        output pc_en, ir_write, mem_write, reg_write, iord, alusrca, alusrcb,
               regdst, memtoreg, pcsource, ext_sel, alu_ctrl, illegal
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_en, ir_write, mem_write, reg_write, iord, alusrca, alusrcb,
               regdst, memtoreg, pcsource, ext_sel, alu_ctrl, illegal
    );
endinterface

// File: rtl/alu_ctrl_dec.sv
// ALU operation decoder: {state class, opcode, funct} -> alu_ctrl, funct_valid.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
module alu_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  alu_cls_t   cls,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       funct_valid
);

    always_comb begin
        funct_valid = 1'b0;
        case (funct)
            FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_JR: funct_valid = 1'b1;
            default:                                        funct_valid = 1'b0;
        endcase
    end

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (cls)
            CLS_SUB: alu_ctrl = ALU_SUB;
            CLS_RTYPE: begin
                case (funct)
                    FN_SUBU: alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            CLS_ITYPE: begin
                case (opcode)
                    OP_ORI:  alu_ctrl = ALU_OR;
                    OP_LUI:  alu_ctrl = ALU_LUI;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control unit: Moore FSM driving datapath enables and mux selects.
// Latency: 3-5 cycles per instruction; outputs combinational from state (pc_en/illegal also from inputs).
// Backpressure: none; the datapath has no stall path, reset abandons the instruction.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mc_ctrl_fsm_if.master bus
);

    state_t     state, state_nxt;
    alu_cls_t   alu_cls;
    logic [2:0] alu_code;
    logic       funct_valid;
    logic       pc_write, branch, ir_wr, mem_wr, reg_wr, decode_illegal;
    logic       iord, alusrca, ext_sel;
    logic [1:0] alusrcb, regdst, memtoreg, pcsource;

    alu_ctrl_dec u_alu_dec (
        .cls         (alu_cls),
        .opcode      (bus.opcode),
        .funct       (bus.funct),
        .alu_ctrl    (alu_code),
        .funct_valid (funct_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = S_FETCH;
        pc_write       = 1'b0;
        branch         = 1'b0;
        ir_wr          = 1'b0;
        mem_wr         = 1'b0;
        reg_wr         = 1'b0;
        decode_illegal = 1'b0;
        iord           = 1'b0;
        alusrca        = 1'b0;
        ext_sel        = 1'b0;
        alusrcb        = SRCB_B;
        regdst         = RDST_RT;
        memtoreg       = M2R_ALUOUT;
        pcsource       = PCSRC_ALU;
        alu_cls        = CLS_ADD;
        case (state)
            S_FETCH: begin
                ir_wr     = 1'b1;
                pc_write  = 1'b1;
                alusrcb   = SRCB_FOUR;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut while dispatching
                alusrcb = SRCB_IMM_SH;
                case (bus.opcode)
                    OP_LW, OP_SW:             state_nxt = S_MEM_ADDR;
                    OP_ADDIU, OP_ORI, OP_LUI: state_nxt = S_EXEC_I;
                    OP_BEQ:                   state_nxt = S_BRANCH;
                    OP_J:                     state_nxt = S_JUMP;
                    OP_JAL:                   state_nxt = S_JAL;
                    OP_RTYPE: begin
                        if (!funct_valid)            decode_illegal = 1'b1;
                        else if (bus.funct == FN_JR) state_nxt = S_JR;
                        else                         state_nxt = S_EXEC_R;
                    end
                    default: decode_illegal = 1'b1;
                endcase
            end
            S_MEM_ADDR: begin
                alusrca   = 1'b1;
                alusrcb   = SRCB_IMM;
                state_nxt = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                iord      = 1'b1;
                state_nxt = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_wr   = 1'b1;
                memtoreg = M2R_MDR;
            end
            S_MEM_WRITE: begin
                iord   = 1'b1;
                mem_wr = 1'b1;
            end
            S_EXEC_R: begin
                alusrca   = 1'b1;
                alu_cls   = CLS_RTYPE;
                state_nxt = S_R_WB;
            end
            S_R_WB: begin
                reg_wr = 1'b1;
                regdst = RDST_RD;
            end
            S_EXEC_I: begin
                alusrca   = 1'b1;
                alusrcb   = SRCB_IMM;
                ext_sel   = (bus.opcode == OP_ORI);
                alu_cls   = CLS_ITYPE;
                state_nxt = S_I_WB;
            end
            S_I_WB: reg_wr = 1'b1;
            S_BRANCH: begin
                alusrca  = 1'b1;
                alu_cls  = CLS_SUB;
                branch   = 1'b1;
                pcsource = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pcsource = PCSRC_JUMP;
            end
            S_JAL: begin
                // PC already holds PC+4 from FETCH, so it is the link value
                pc_write = 1'b1;
                pcsource = PCSRC_JUMP;
                reg_wr   = 1'b1;
                regdst   = RDST_RA;
                memtoreg = M2R_PC;
            end
            S_JR: begin
                pc_write = 1'b1;
                pcsource = PCSRC_A;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Write strobes are masked during reset so nothing commits while rst is high
    assign bus.pc_en     = ~rst & (pc_write | (branch & bus.zero));
    assign bus.ir_write  = ~rst & ir_wr;
    assign bus.mem_write = ~rst & mem_wr;
    assign bus.reg_write = ~rst & reg_wr;
    assign bus.illegal   = ~rst & decode_illegal;
    assign bus.iord      = iord;
    assign bus.alusrca   = alusrca;
    assign bus.alusrcb   = alusrcb;
    assign bus.regdst    = regdst;
    assign bus.memtoreg  = memtoreg;
    assign bus.pcsource  = pcsource;
    assign bus.ext_sel   = ext_sel;
    assign bus.alu_ctrl  = alu_code;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: stimulus pushes the per-cycle expected control
// word of each instruction, a negedge monitor pops and compares.
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic       pc_en;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       iord;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic [1:0] pcsource;
        logic       ext_sel;
        logic [2:0] alu_ctrl;
        logic       illegal;
    } ctl_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    ctl_t  exp_q[$];
    string tag_q[$];

    mc_ctrl_fsm_if bus ();

    mc_ctrl_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic ctl_t sample();
        ctl_t s;
        s.pc_en     = bus.pc_en;
        s.ir_write  = bus.ir_write;
        s.mem_write = bus.mem_write;
        s.reg_write = bus.reg_write;
        s.iord      = bus.iord;
        s.alusrca   = bus.alusrca;
        s.alusrcb   = bus.alusrcb;
        s.regdst    = bus.regdst;
        s.memtoreg  = bus.memtoreg;
        s.pcsource  = bus.pcsource;
        s.ext_sel   = bus.ext_sel;
        s.alu_ctrl  = bus.alu_ctrl;
        s.illegal   = bus.illegal;
        return s;
    endfunction

    function automatic void check(input string tag, input ctl_t got, input ctl_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b (pc_en,ir,mw,rw,iord,srca,srcb,rdst,m2r,pcsrc,ext,alu,ill)",
                     tag, got, exp);
        end
    endfunction

    function automatic void push(input ctl_t c, input string tag);
        exp_q.push_back(c);
        tag_q.push_back(tag);
    endfunction

    function automatic ctl_t reset_word();
        ctl_t c = '0;
        c.alusrcb = 2'b01;
        return c;
    endfunction

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001001,
            6'b001101, 6'b001111, 6'b000010, 6'b000011: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic fn_legal(input logic [5:0] fn);
        case (fn)
            6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010, 6'b001000: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Reference: list of control words an instruction produces, one per cycle
    function automatic int expect_instr(input logic [5:0] op, input logic [5:0] fn,
                                        input logic zf, input string nm);
        ctl_t c;
        c = '0; c.pc_en = 1'b1; c.ir_write = 1'b1; c.alusrcb = 2'b01;
        push(c, {nm, ".fetch"});
        c = '0; c.alusrcb = 2'b11;
        if (!op_legal(op) || (op == 6'b000000 && !fn_legal(fn))) begin
            c.illegal = 1'b1;
            push(c, {nm, ".decode_illegal"});
            return 2;
        end
        push(c, {nm, ".decode"});
        c = '0;
        if (op == 6'b100011 || op == 6'b101011) begin
            c.alusrca = 1'b1; c.alusrcb = 2'b10;
            push(c, {nm, ".addr"});
            c = '0; c.iord = 1'b1;
            if (op == 6'b101011) begin
                c.mem_write = 1'b1;
                push(c, {nm, ".mem_write"});
                return 4;
            end
            push(c, {nm, ".mem_read"});
            c = '0; c.reg_write = 1'b1; c.memtoreg = 2'b01;
            push(c, {nm, ".mem_wb"});
            return 5;
        end
        if (op == 6'b000000 && fn == 6'b001000) begin
            c.pc_en = 1'b1; c.pcsource = 2'b11;
            push(c, {nm, ".jr"});
            return 3;
        end
        if (op == 6'b000000) begin
            c.alusrca = 1'b1;
            case (fn)
                6'b100011: c.alu_ctrl = 3'b001;
                6'b100100: c.alu_ctrl = 3'b010;
                6'b100101: c.alu_ctrl = 3'b011;
                6'b101010: c.alu_ctrl = 3'b100;
                default:   c.alu_ctrl = 3'b000;
            endcase
            push(c, {nm, ".exec_r"});
            c = '0; c.reg_write = 1'b1; c.regdst = 2'b01;
            push(c, {nm, ".r_wb"});
            return 4;
        end
        if (op == 6'b001001 || op == 6'b001101 || op == 6'b001111) begin
            c.alusrca = 1'b1; c.alusrcb = 2'b10;
            c.ext_sel  = (op == 6'b001101);
            c.alu_ctrl = (op == 6'b001101) ? 3'b011 : (op == 6'b001111) ? 3'b101 : 3'b000;
            push(c, {nm, ".exec_i"});
            c = '0; c.reg_write = 1'b1;
            push(c, {nm, ".i_wb"});
            return 4;
        end
        if (op == 6'b000100) begin
            c.alusrca = 1'b1; c.alu_ctrl = 3'b001; c.pcsource = 2'b01; c.pc_en = zf;
            push(c, {nm, ".branch"});
            return 3;
        end
        c.pc_en = 1'b1; c.pcsource = 2'b10;
        if (op == 6'b000011) begin
            c.reg_write = 1'b1; c.regdst = 2'b10; c.memtoreg = 2'b10;
        end
        push(c, {nm, ".jump"});
        return 3;
    endfunction

    // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 of the next FETCH
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic zf, input string nm);
        int n;
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = zf;
        n = expect_instr(op, fn, zf, nm);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        ctl_t  e;
        string t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check(t, sample(), e);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [5:0] ops [8];
        logic [5:0] fns [6];
        logic [5:0] op, fn;
        int         sel, n;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                6'b001001, 6'b001101, 6'b001111, 6'b000010};
        fns = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010, 6'b001000};
        bus.opcode = '0;
        bus.funct  = '0;
        bus.zero   = 1'b0;
        #1 rst = 1'b1;
        push(reset_word(), "reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        run_instr(6'b100011, 6'b000000, 1'b0, "lw");
        run_instr(6'b000000, 6'b100001, 1'b0, "addu");
        run_instr(6'b000000, 6'b101010, 1'b1, "slt");
        run_instr(6'b000100, 6'b000000, 1'b1, "beq_z1");
        run_instr(6'b000100, 6'b000000, 1'b0, "beq_z0");
        run_instr(6'b000011, 6'b000000, 1'b0, "jal");
        run_instr(6'b001101, 6'b000000, 1'b0, "ori");
        run_instr(6'b111111, 6'b000000, 1'b0, "ill_op");
        run_instr(6'b000000, 6'b000000, 1'b0, "ill_fn");
        run_instr(6'b000000, 6'b001000, 1'b0, "jr");

        // sw interrupted by reset while in its memory-write cycle
        bus.opcode = 6'b101011;
        bus.funct  = 6'b000000;
        n = expect_instr(6'b101011, 6'b000000, 1'b0, "sw_rst");
        repeat (n - 1) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check("sw_rst.immediate", sample(), reset_word());
        push(reset_word(), "sw_rst.hold");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 9);
            fn  = 6'($urandom_range(0, 63));
            if (sel < 8) begin
                op = ops[sel];
                if (op == 6'b000000) fn = fns[$urandom_range(0, 5)];
            end else if (sel == 8) begin
                do op = 6'($urandom_range(0, 63)); while (op_legal(op));
            end else begin
                op = 6'b000000;
                do fn = 6'($urandom_range(0, 63)); while (fn_legal(fn));
            end
            run_instr(op, fn, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0 pending", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multicycle control unit for the MIPS datapath. It is a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath register enable and every 2:1/4:1 mux select, so it sits directly upstream of the datapath muxes. Select buses are 2-bit `{s1,s0}` and map straight onto mux inputs: a=00, b=01, c=10, d=11.

## Interface
- No parameters; all encodings live in the shared package.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  6  IR[31:26]; valid from DECODE until next FETCH.
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag.
- `pc_en`  out  1  PC load = pc_write | (branch & zero).
- `ir_write`  out  1  IR load.
- `mem_write`  out  1  data memory write.
- `reg_write`  out  1  register-file write.
- `iord`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `alusrca`  out  1  0 = PC, 1 = A.
- `alusrcb`  out  2  00 = B, 01 = const 4, 10 = ext imm, 11 = ext imm<<2.
- `regdst`  out  2  00 = rt, 01 = rd, 10 = $31.
- `memtoreg`  out  2  00 = ALUOut, 01 = MDR, 10 = PC.
- `pcsource`  out  2  00 = ALU, 01 = ALUOut, 10 = jump target, 11 = A.
- `ext_sel`  out  1  0 = sign-extend, 1 = zero-extend.
- `alu_ctrl`  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 LUI.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode or funct.

## Operation
- Supported instructions:
  - R-type (000000) with funct addu 100001, subu 100011, and 100100, or 100101, slt 101010, jr 001000.
  - lw 100011, sw 101011, beq 000100, addiu 001001, ori 001101, lui 001111, j 000010, jal 000011.
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, JAL, JR. Encoding is 4-bit binary.
- FETCH: ir_write=1, pc_en=1, iord=0, alusrca=0, alusrcb=01, alu_ctrl=ADD, pcsource=00. Next state DECODE.
- DECODE: alusrca=0, alusrcb=11, alu_ctrl=ADD (branch target into ALUOut). Dispatch:
  - lw/sw → MEM_ADDR
  - R-type non-jr → EXEC_R
  - jr → JR
  - addiu/ori/lui → EXEC_I
  - beq → BRANCH
  - j → JUMP
  - jal → JAL
  - anything else → FETCH, with illegal=1 for this cycle.
- MEM_ADDR: alusrca=1, alusrcb=10, ADD. Next state MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: iord=1 → MEM_WB.
- MEM_WB: reg_write=1, regdst=00, memtoreg=01 → FETCH.
- MEM_WRITE: iord=1, mem_write=1 → FETCH.
- EXEC_R: alusrca=1, alusrcb=00, alu_ctrl from funct → R_WB.
- R_WB: reg_write=1, regdst=01, memtoreg=00 → FETCH.
- EXEC_I: alusrca=1, alusrcb=10, ext_sel=1 for ori only; alu_ctrl ADD/OR/LUI → I_WB.
- I_WB: reg_write=1, regdst=00, memtoreg=00 → FETCH.
- BRANCH: alusrca=1, alusrcb=00, SUB, branch=1, pcsource=01 → FETCH.
- JUMP: pc_en=1, pcsource=10 → FETCH.
- JAL: pc_en=1, pcsource=10, reg_write=1, regdst=10, memtoreg=10. This writes the already-incremented PC to $31 → FETCH.
- JR: pc_en=1, pcsource=11 → FETCH.
- Every output not listed for a state is 0, or 00 for 2-bit buses.

## Timing
- Outputs are combinational from the state register only. Exceptions: pc_en also depends on `zero`; `illegal` also depends on opcode/funct.
- Cycle counts per instruction: lw 5; sw, R-type, I-type 4; beq, j, jal, jr 3.
- Reset: state goes to FETCH asynchronously. While rst=1, pc_en, ir_write, mem_write, reg_write and illegal are forced to 0; mux selects show FETCH values. The first rising edge after deassertion executes FETCH.
- Reset mid-instruction abandons it; no partial write may occur after rst rises.
- beq with zero=0: pc_en=0 in BRANCH, and PC holds the value written in FETCH.
- An unknown funct under opcode 000000 is illegal and handled like an unknown opcode.

## Structure
- Package `mc_ctrl_pkg` holds:
  - state enumeration
  - opcode and funct constants
  - alu_ctrl codes
  - alusrcb/regdst/memtoreg/pcsource select codes
- Sub-module `alu_ctrl_dec`: combinational mapping {state class, opcode, funct} → {alu_ctrl, funct_valid}.

## Test plan
- Reset asserted mid-MEM_WRITE of sw: mem_write drops to 0 immediately; after release, FETCH shows ir_write=1, pc_en=1, alusrcb=01.
- lw (opcode 100011): states FETCH→DECODE→MEM_ADDR→MEM_READ→MEM_WB over 5 cycles; in MEM_WB reg_write=1, regdst=00, memtoreg=01.
- addu then slt: EXEC_R alu_ctrl=000, then 100; R_WB regdst=01.
- beq with zero=1: pc_en=1, pcsource=01 in cycle 3. Repeat with zero=0: pc_en=0.
- jal: cycle 3 has pc_en=1, pcsource=10, reg_write=1, regdst=10, memtoreg=10. ori has ext_sel=1, alu_ctrl=011.
- Opcode 111111, and opcode 000000 with funct 000000: illegal pulses for one cycle in DECODE, then FETCH; no write enable asserted.
